// File: rtl/sgdmac_axi_sram_slave.sv
// AXI3 slave that terminates the SGDMAC master port onto a single-port synchronous SRAM.
// One burst in flight at a time; round-robin between read and write when both request together.
module sgdmac_axi_sram_slave #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        awid_i,
  input  logic [31:0]       awaddr_i,
  input  logic [3:0]        awlen_i,
  input  logic [2:0]        awsize_i,
  input  logic [1:0]        awburst_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [3:0]        wid_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic              wlast_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [3:0]        bid_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [3:0]        arid_i,
  input  logic [31:0]       araddr_i,
  input  logic [3:0]        arlen_i,
  input  logic [2:0]        arsize_i,
  input  logic [1:0]        arburst_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [3:0]        rid_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rlast_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  state_e            state_q, state_d;
  logic [3:0]        id_q, id_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              incr_q, incr_d;
  logic              grant_rd_q, grant_rd_d;   // 1 = read was granted last

  logic              mem_req;
  logic              last_beat;
  logic [MEM_AW-1:0] addr_next;
  logic              aw_legal, ar_legal;

  // Signals that the protocol carries but this slave deliberately ignores.
  logic unused_bits;
  assign unused_bits = ^{wid_i, awaddr_i[31:MEM_AW+2], awaddr_i[1:0],
                         araddr_i[31:MEM_AW+2], araddr_i[1:0]};

  assign last_beat = (cnt_q == len_q);
  assign addr_next = incr_q ? addr_q + MEM_AW'(1) : addr_q;
  assign aw_legal  = (awsize_i == SIZE_WORD) && !awburst_i[1];
  assign ar_legal  = (arsize_i == SIZE_WORD) && !arburst_i[1];

  // A strobe raised in the reset cycle must not reach the SRAM.
  assign mem_cs_o = mem_req & rst_n;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    incr_d      = incr_q;
    grant_rd_d  = grant_rd_q;
    awready_o   = 1'b0;
    arready_o   = 1'b0;
    wready_o    = 1'b0;
    bvalid_o    = 1'b0;
    bid_o       = '0;
    bresp_o     = RESP_OKAY;
    rvalid_o    = 1'b0;
    rid_o       = '0;
    rdata_o     = '0;
    rresp_o     = RESP_OKAY;
    rlast_o     = 1'b0;
    mem_req     = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = addr_q;
    mem_wdata_o = '0;
    mem_be_o    = '0;

    unique case (state_q)
      S_IDLE: begin
        awready_o = awvalid_i & (~arvalid_i | grant_rd_q);
        arready_o = arvalid_i & (~awvalid_i | ~grant_rd_q);
        if (awready_o) begin
          id_d       = awid_i;
          addr_d     = awaddr_i[MEM_AW+1:2];
          len_d      = awlen_i;
          incr_d     = awburst_i[0];
          err_d      = ~aw_legal;
          cnt_d      = '0;
          grant_rd_d = 1'b0;
          state_d    = S_WR_DATA;
        end else if (arready_o) begin
          id_d       = arid_i;
          addr_d     = araddr_i[MEM_AW+1:2];
          len_d      = arlen_i;
          incr_d     = arburst_i[0];
          err_d      = ~ar_legal;
          cnt_d      = '0;
          grant_rd_d = 1'b1;
          state_d    = S_RD_REQ;
        end
      end

      S_WR_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          mem_req     = ~err_q;
          mem_we_o    = 1'b1;
          mem_be_o    = wstrb_i;
          mem_wdata_o = wdata_i;
          addr_d      = addr_next;
          // The beat count, not wlast, ends the burst; a disagreement only flags the error.
          if (wlast_i != last_beat) err_d = 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_WR_RESP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_WR_RESP: begin
        bvalid_o = 1'b1;
        bid_o    = id_q;
        bresp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (bready_i) state_d = S_IDLE;
      end

      S_RD_REQ: begin
        mem_req = ~err_q;
        addr_d  = addr_next;
        state_d = S_RD_DATA;
      end

      S_RD_DATA: begin
        rvalid_o = 1'b1;
        rid_o    = id_q;
        rlast_o  = last_beat;
        rdata_o  = err_q ? '0 : mem_rdata_i;
        rresp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (rready_i) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            // Prefetch the next beat so the SRAM data lands as this one retires.
            mem_req = ~err_q;
            addr_d  = addr_next;
            cnt_d   = cnt_q + 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      incr_q     <= 1'b0;
      grant_rd_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      incr_q     <= incr_d;
      grant_rd_q <= grant_rd_d;
    end
  end

endmodule

// File: tb/tb_sgdmac_axi_sram_slave.sv
// Directed bench for sgdmac_axi_sram_slave with a behavioural SRAM (8-bit word address).
module tb_sgdmac_axi_sram_slave;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    awid_i, arid_i, wid_i;
  logic [31:0]   awaddr_i, araddr_i, wdata_i;
  logic [3:0]    awlen_i, arlen_i, wstrb_i;
  logic [2:0]    awsize_i, arsize_i;
  logic [1:0]    awburst_i, arburst_i;
  logic          awvalid_i, arvalid_i, wvalid_i, wlast_i, bready_i, rready_i;
  logic          awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o;
  logic [3:0]    bid_o, rid_o;
  logic [1:0]    bresp_o, rresp_o;
  logic [31:0]   rdata_o;
  logic          mem_cs_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o, mem_rdata_i;
  logic [3:0]    mem_be_o;

  logic [31:0]   mem [0:(1<<AW)-1];
  int            cs_count = 0;
  int            compared = 0;
  int            mismatched = 0;

  sgdmac_axi_sram_slave #(.MEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: preloaded pattern, byte-enabled writes, read data held until next strobe.
  initial begin
    mem_rdata_i = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hDEAD_0000 + i;
    forever begin
      @(posedge clk);
      if (mem_cs_o) begin
        cs_count++;
        if (mem_we_o) begin
          for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
        end else begin
          mem_rdata_i <= mem[mem_addr_o];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, 32'({awready_o, arready_o, wready_o, bvalid_o, rvalid_o, mem_cs_o, rlast_o}), 32'd0);
    chk({tag, "_fld"}, 32'({bid_o, bresp_o, rid_o, rresp_o}), 32'd0);
    chk({tag, "_rdata"}, rdata_o, 32'd0);
  endtask

  task automatic aw_req(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input string tag);
    int n;
    awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
    awvalid_i = 1'b1;
    n = 0;
    #1;
    while (!awready_o && n < 20) begin tick(); n++; end
    chk({tag, "_awready"}, 32'(awready_o), 32'd1);
    @(posedge clk); #1;
    awvalid_i = 1'b0;
  endtask

  task automatic ar_req(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input string tag);
    int n;
    arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = burst;
    arvalid_i = 1'b1;
    n = 0;
    #1;
    while (!arready_o && n < 20) begin tick(); n++; end
    chk({tag, "_arready"}, 32'(arready_o), 32'd1);
    @(posedge clk); #1;
    arvalid_i = 1'b0;
  endtask

  // Beats carry base+i; wlast is raised on beat last_at.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
                          input int last_at, input logic [1:0] exp_resp, input string tag);
    aw_req(id, addr, len, size, burst, tag);
    for (int i = 0; i <= int'(len); i++) begin
      wdata_i = base + i; wstrb_i = 4'hF; wlast_i = (i == last_at); wvalid_i = 1'b1;
      #1;
      chk($sformatf("%s_wready%0d", tag, i), 32'(wready_o), 32'd1);
      tick();
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
    #1;
    chk({tag, "_bvalid"}, 32'(bvalid_o), 32'd1);
    chk({tag, "_bresp"}, 32'(bresp_o), 32'(exp_resp));
    chk({tag, "_bid"}, 32'(bid_o), 32'(id));
    bready_i = 1'b1;
    tick();
    bready_i = 1'b0;
    #1;
    chk({tag, "_bdone"}, 32'(bvalid_o), 32'd0);
  endtask

  // Expected beat i is base+i, or 0 with SLVERR when the request is illegal.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
                         input logic stall, input logic err, input string tag);
    logic [31:0] exp_d;
    ar_req(id, addr, len, size, burst, tag);
    #1;
    chk({tag, "_rreq"}, 32'(rvalid_o), 32'd0);
    tick();
    for (int i = 0; i <= int'(len); i++) begin
      exp_d = err ? 32'd0 : base + i;
      if (stall) begin
        rready_i = 1'b0;
        #1;
        chk($sformatf("%s_stall%0d", tag, i), rdata_o, exp_d);
        tick();
        chk($sformatf("%s_hold%0d", tag, i), rdata_o, exp_d);
      end
      rready_i = 1'b1;
      #1;
      chk($sformatf("%s_rvalid%0d", tag, i), 32'(rvalid_o), 32'd1);
      chk($sformatf("%s_rdata%0d", tag, i), rdata_o, exp_d);
      chk($sformatf("%s_rlast%0d", tag, i), 32'(rlast_o), 32'(i == int'(len)));
      chk($sformatf("%s_rresp%0d", tag, i), 32'({rid_o, rresp_o}), 32'({id, err ? 2'b10 : 2'b00}));
      tick();
    end
    rready_i = 1'b0;
    #1;
    chk({tag, "_rdone"}, 32'(rvalid_o), 32'd0);
  endtask

  initial begin
    int base_cs, g;
    logic [3:0] order;
    int both;

    rst_n = 1'b0;
    awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
    arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0; arvalid_i = 1'b0;
    wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0;
    bready_i = 1'b0; rready_i = 1'b0;
    tick(); tick();
    chk_quiet("reset");
    rst_n = 1'b1;
    tick();

    // INCR write of 4 beats to words 0x40..0x43.
    base_cs = cs_count;
    do_write(4'd2, 32'h100, 4'd3, 3'b010, 2'b01, 32'hA0, 3, 2'b00, "incr_wr");
    chk("incr_wr_cs", 32'(cs_count - base_cs), 32'd4);
    chk("incr_wr_m40", mem[8'h40], 32'hA0);
    chk("incr_wr_m43", mem[8'h43], 32'hA3);
    chk("incr_wr_m44", mem[8'h44], 32'hDEAD_0044);

    // INCR read back with rready toggling.
    base_cs = cs_count;
    do_read(4'd5, 32'h100, 4'd3, 3'b010, 2'b01, 32'hA0, 1'b1, 1'b0, "incr_rd");
    chk("incr_rd_cs", 32'(cs_count - base_cs), 32'd4);

    // Arbitration out of reset with both requests held: expect R,W,R,W.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    awid_i = 4'd9; awaddr_i = 32'h300; awlen_i = 4'd0; awsize_i = 3'b010; awburst_i = 2'b01;
    arid_i = 4'd10; araddr_i = 32'h100; arlen_i = 4'd0; arsize_i = 3'b010; arburst_i = 2'b01;
    wdata_i = 32'h5A5A_5A5A; wstrb_i = 4'hF; wlast_i = 1'b1; wvalid_i = 1'b1;
    rready_i = 1'b1; bready_i = 1'b1;
    awvalid_i = 1'b1; arvalid_i = 1'b1;
    g = 0; order = '0; both = 0;
    for (int n = 0; n < 40 && g < 4; n++) begin
      #1;
      if (awready_o && arready_o) both++;
      if (arready_o) begin order[g] = 1'b1; g++; end
      else if (awready_o) begin order[g] = 1'b0; g++; end
      @(posedge clk);
    end
    #1;
    awvalid_i = 1'b0; arvalid_i = 1'b0;
    tick(); tick();
    wvalid_i = 1'b0; wlast_i = 1'b0; rready_i = 1'b0; bready_i = 1'b0;
    chk("arb_grants", 32'(g), 32'd4);
    chk("arb_order", 32'(order), 32'b0101);
    chk("arb_both", 32'(both), 32'd0);
    chk("arb_wr_mem", mem[8'hC0], 32'h5A5A_5A5A);

    // Illegal size on read and WRAP burst on write: no SRAM access, SLVERR.
    base_cs = cs_count;
    do_read(4'd6, 32'h100, 4'd1, 3'b000, 2'b01, 32'hA0, 1'b0, 1'b1, "bad_rd");
    do_write(4'd7, 32'h140, 4'd1, 3'b010, 2'b10, 32'hE0, 1, 2'b10, "bad_wr");
    chk("bad_cs", 32'(cs_count - base_cs), 32'd0);
    chk("bad_wr_m50", mem[8'h50], 32'hDEAD_0050);

    // Early wlast: all 4 beats still consumed, SLVERR.
    do_write(4'd1, 32'h200, 4'd3, 3'b010, 2'b01, 32'hF0, 1, 2'b10, "wlast_early");

    // FIXED burst: only word 0x08 written, final value is the last beat.
    do_write(4'd3, 32'h20, 4'd2, 3'b010, 2'b00, 32'hC0, 2, 2'b00, "fixed_wr");
    chk("fixed_m08", mem[8'h08], 32'hC2);
    chk("fixed_m09", mem[8'h09], 32'hDEAD_0009);

    // INCR from the top word wraps to word 0; upper address bits are ignored.
    do_write(4'd4, 32'h1000_03FC, 4'd1, 3'b010, 2'b01, 32'hB0, 1, 2'b00, "wrap_wr");
    chk("wrap_mff", mem[8'hFF], 32'hB0);
    chk("wrap_m00", mem[8'h00], 32'hB1);
    do_read(4'd11, 32'h3FC, 4'd1, 3'b010, 2'b01, 32'hB0, 1'b0, 1'b0, "wrap_rd");

    // Reset in the middle of a write burst.
    base_cs = cs_count;
    aw_req(4'd8, 32'h280, 4'd3, 3'b010, 2'b01, "rst_wr");
    for (int i = 0; i < 2; i++) begin
      wdata_i = 32'hD0 + i; wstrb_i = 4'hF; wlast_i = 1'b0; wvalid_i = 1'b1;
      tick();
    end
    wdata_i = 32'hD2;
    rst_n = 1'b0;
    tick();
    chk_quiet("rst_mid");
    tick();
    rst_n = 1'b1; wvalid_i = 1'b0;
    tick();
    chk("rst_cs", 32'(cs_count - base_cs), 32'd2);
    chk("rst_mA1", mem[8'hA1], 32'hD1);
    chk("rst_mA2", mem[8'hA2], 32'hDEAD_00A2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
